bcd_serial_add_ctrl: RTL and testbench
======================================

BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

Interface
REQ-001 Parameter: NDIGITS, 4, number of BCD digits per operand (valid range 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to add; sampled only in IDLE.
REQ-005 Port: a  input  4*NDIGITS  operand A, packed BCD, digit 0 in bits [3:0].
REQ-006 Port: b  input  4*NDIGITS  operand B, same packing as a.
REQ-007 Port: busy  output  1  high while an addition is in progress (ADD state).
REQ-008 Port: done  output  1  one-cycle pulse when sum/cout are final.
REQ-009 Port: sum  output  4*NDIGITS  packed BCD result.
REQ-010 Port: cout  output  1  decimal carry out of the most significant digit.
REQ-011 Port: err  output  1  invalid-digit flag; constant 0 when BCD_CHECK_EN is undefined.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ADD, DONE.
REQ-013 IDLE with start=1 at edge k: latch a/b, clear the digit index and the internal carry, clear sum/cout/err, then go to ADD.
REQ-014 ADD SHALL process one digit per cycle, from digit 0 to digit NDIGITS-1, at edges k+1 .. k+NDIGITS.
REQ-015 Per-digit step: t = a_i + b_i + carry (5 bits); if t>9 then sum_i = t-10 (4-bit) and carry=1, else sum_i = t and carry=0.
REQ-016 At edge k+NDIGITS the last digit SHALL be written, cout = final carry, state -> DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE; latency from start edge to done-high is NDIGITS cycles.
REQ-018 busy SHALL be 1 exactly in ADD; done SHALL be 1 exactly in DONE; both SHALL be registered (no combinational path from start).
REQ-019 sum, cout and err SHALL hold their values from DONE until the next accepted start.
REQ-020 start in ADD or DONE SHALL be ignored and SHALL NOT be queued; changes to a/b after acceptance SHALL have no effect.
REQ-021 Digit index SHALL be a counter of width clog2(NDIGITS)+1 and SHALL NOT wrap; the ADD->DONE exit is taken at index NDIGITS-1.

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, err=0, carry=0, index=0.
REQ-023 Reset during ADD or DONE SHALL abort the operation with no done pulse; the first start after release SHALL be accepted normally.

Configuration
REQ-024 Macro BCD_CHECK_EN defined: any latched digit of a or b >9 SHALL set err=1 at the edge that processes that digit; err SHALL remain 1 until the next accepted start; the addition still completes with the REQ-015 rule.
REQ-025 Macro BCD_CHECK_EN undefined: no checking logic is built and err is tied to 0.

Structure
REQ-026 A shared package bcd_pkg SHALL hold the state enum type (IDLE/ADD/DONE), the BCD digit typedef (4-bit) and constant BCD_MAX=9.
REQ-027 The per-digit step SHALL be the combinational sub-module bcd_digit_add (a, b, cin -> s, cout), instantiated once and reused for every digit.

Verification (NDIGITS=4)
REQ-028 a=0x1234, b=0x8766, start pulse -> done 4 cycles later, sum=0x0000, cout=1, busy high for exactly 4 cycles.
REQ-029 a=0x9999, b=0x0001 -> sum=0x0000, cout=1; then a=0x0450, b=0x0549 -> sum=0x0999, cout=0.
REQ-030 start held high through ADD and DONE -> only one operation per IDLE visit; a/b changed mid-ADD do not alter the result.
REQ-031 rst_n pulsed low at the second ADD cycle -> outputs go to 0 immediately, no done; the next start with a=0x0005, b=0x0005 -> sum=0x0010, cout=0.
REQ-032 BCD_CHECK_EN defined: a=0x00A0, b=0x0000 -> err=1 from the digit-1 edge through done; the next valid start clears err.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder.
package bcd_pkg;

  // Controller states: waiting, adding one digit per cycle, result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One packed BCD digit.
  typedef logic [3:0] bcd_digit_t;

  // Largest legal BCD digit value.
  localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit decimal adder: s = (a + b + cin) mod 10, cout = decimal carry.
// Purely combinational; the controller reuses one instance for every digit.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t s,
  output logic       cout
);

  logic [4:0] t;

  // Binary sum, then subtract ten when it exceeds a decimal digit.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    s    = '0;
    cout = 1'b0;
    t    = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (t > {1'b0, BCD_MAX}) begin
      // Low nibble of (t - 10) equals t[3:0] - 10 modulo 16.
      s    = t[3:0] - 4'd10;
      cout = 1'b1;
    end else begin
      s    = t[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Serial BCD adder controller: latches two NDIGITS-digit packed BCD operands
// on an accepted start, adds one digit per cycle (digit 0 first), then pulses
// done for one cycle. Results hold until the next accepted start.
// Optional feature macro: BCD_CHECK_EN -- flags any operand digit above 9 on err.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   a,
  input  logic [4*NDIGITS-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NDIGITS-1:0]   sum,
  output logic                   cout,
  output logic                   err
);

  // Index has one spare bit so it can never wrap; the select uses the low bits.
  localparam int IW = $clog2(NDIGITS) + 1;
  localparam int SW = $clog2(NDIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);

  state_t                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      carry_q, carry_d;
  logic                      cout_q, cout_d;
  bcd_digit_t [NDIGITS-1:0]  a_q, a_d;
  bcd_digit_t [NDIGITS-1:0]  b_q, b_d;
  bcd_digit_t [NDIGITS-1:0]  sum_q, sum_d;

  logic [SW-1:0]             sel;
  bcd_digit_t                dig_a, dig_b, dig_s;
  logic                      dig_c;

  assign sel   = idx_q[SW-1:0];
  assign dig_a = a_q[sel];
  assign dig_b = b_q[sel];

  bcd_digit_add u_digit_add (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .s    (dig_s),
    .cout (dig_c)
  );

`ifdef BCD_CHECK_EN
  logic err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Status flags decode straight from the state register, so they are registered.
  assign busy = (state_q == ADD);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

  // Next-state and datapath update for the three-state controller.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
`ifdef BCD_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          carry_d = 1'b0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef BCD_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[sel] = dig_s;
        carry_d    = dig_c;
`ifdef BCD_CHECK_EN
        if ((dig_a > BCD_MAX) || (dig_b > BCD_MAX)) begin
          err_d = 1'b1;
        end
`endif
        if (idx_q == LAST_IDX) begin
          cout_d  = dig_c;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
`ifdef BCD_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
`ifdef BCD_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl (NDIGITS=4); honours BCD_CHECK_EN.
module tb_bcd_serial_add_ctrl;

`ifdef BCD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, cout, err;
  logic [15:0] sum;

  int errors = 0;
  int checks = 0;

  bcd_serial_add_ctrl #(.NDIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation: start accepted at edge k, operands scribbled after
  // acceptance, err tracked per cycle, done expected after four ADD cycles.
  task automatic run_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                        input logic [15:0] exp_sum, input logic exp_cout,
                        input int bad_digit, input bit hold);
    int  busy_cnt = 0;
    bit  seen = 1'b0;
    logic exp_err;
    @(negedge clk);
    a = op_a; b = op_b; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      exp_err = CHK && (bad_digit >= 0) && (i > bad_digit);
      check({tag, "_err_cycle"}, 32'(err), 32'(exp_err));
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      else begin a = 16'h9999; b = 16'h9999; end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    start = 1'b0;
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'({busy, done}), 32'd0);
    check({tag, "_sum_hold"}, 32'({cout, sum}), 32'({exp_cout, exp_sum}));
    @(negedge clk);
    check({tag, "_no_requeue"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    int done_cnt;
    int busy_cnt;

    // Power-on reset: outputs forced to zero while rst_n is low.
    #1 rst_n = 1'b0;
    #20;
    check("reset_outputs", 32'({busy, done, cout, err, sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'({busy, done}), 32'd0);

    // Basic additions with carries through every digit.
    run_op("add_1234_8766", 16'h1234, 16'h8766, 16'h0000, 1'b1, -1, 1'b0);
    run_op("add_9999_0001", 16'h9999, 16'h0001, 16'h0000, 1'b1, -1, 1'b0);
    run_op("add_0450_0549", 16'h0450, 16'h0549, 16'h0999, 1'b0, -1, 1'b0);

    // start held high through ADD and DONE: exactly one operation.
    run_op("hold_start", 16'h1111, 16'h2222, 16'h3333, 1'b0, -1, 1'b1);

    // Reset in the second ADD cycle aborts with no done pulse.
    @(negedge clk);
    a = 16'h1238; b = 16'h0005; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2;
    check("pre_abort_busy", 32'(busy), 32'd1);
    check("pre_abort_sum", 32'(sum), 32'h0003);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 32'({busy, done, cout, err, sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_no_busy", 32'(busy_cnt), 32'd0);
    run_op("after_abort_5_5", 16'h0005, 16'h0005, 16'h0010, 1'b0, -1, 1'b0);

    // Invalid digit in position 1: A+0 -> 0 carry 1; err only with checking built.
    run_op("bad_digit_00A0", 16'h00A0, 16'h0000, 16'h0100, 1'b0, 1, 1'b0);
    check("bad_digit_err_hold", 32'(err), 32'(CHK));
    run_op("clear_err_0001", 16'h0001, 16'h0002, 16'h0003, 1'b0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
